fpga_debug_display: RTL and testbench

- Parametrised successor to the board debug front end.
- Shows the PC of a selected pipeline stage, or a selected register value, on NUM_DIGITS active-low 7-segment digits.
- Converts serially, one digit per clock, least-significant digit first, in decimal or hex. Shows the inverted opcode of the selected stage on LEDR.
- Sits between the pipeline debug taps and the board HEX/LEDR/SW pins.

---
 rtl/fpga_debug_pkg.sv | 43 ++++
 rtl/fpga_debug_display_digit_serializer.sv | 94 +++++++++
 rtl/fpga_debug_display.sv | 129 ++++++++++++
 tb/tb_fpga_debug_display.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_debug_pkg.sv
// Shared types and helpers for the board debug display.
// Holds the blank pattern, 7-seg lookup, state type and stage index names.
package fpga_debug_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        CONVERT,
        HOLD
    } state_e;

    localparam int FETCH     = 0;
    localparam int DECODE    = 1;
    localparam int ISSUE     = 2;
    localparam int EXECUTE   = 3;
    localparam int MEMORY    = 4;
    localparam int COMMIT    = 5;
    localparam int WRITEBACK = 6;

    function automatic logic [6:0] seg_lut(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fpga_debug_display_digit_serializer.sv
// Serial radix converter: one digit per clock, least significant first.
// Ports: clk, rst_n, restart, hex (radix), source -> digits, written, conv_done.
module digit_serializer #(
    parameter int NUM_DIGITS = 6,
    parameter int VALUE_W    = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    restart,
    input  logic                    hex,
    input  logic [VALUE_W-1:0]      source,
    output logic [NUM_DIGITS*4-1:0] digits,
    output logic [NUM_DIGITS-1:0]   written,
    output logic                    conv_done
);
    import fpga_debug_pkg::*;

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

    state_e               state_q;
    state_e               state_d;
    logic [VALUE_W-1:0]   work_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 hex_q;
    logic                 step;
    logic                 finish;

    // The restart edge divides the fresh source; later edges divide work.
    logic                 use_hex;
    logic [VALUE_W-1:0]   div_in;
    logic [VALUE_W-1:0]   base_v;
    logic [VALUE_W-1:0]   quo;
    logic [3:0]           rem;

    assign use_hex = restart ? hex : hex_q;
    assign div_in  = restart ? source : work_q;
    assign base_v  = use_hex ? VALUE_W'(16) : VALUE_W'(10);
    assign quo     = div_in / base_v;
    assign rem     = 4'(div_in % base_v);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = (NUM_DIGITS == 1) ? HOLD : CONVERT;
        end else if (state_q == CONVERT && idx_q == LAST) begin
            state_d = HOLD;
        end
    end

    always_comb begin
        step   = !restart && (state_q == CONVERT);
        finish = step && (idx_q == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q    <= '0;
            idx_q     <= '0;
            hex_q     <= 1'b0;
            digits    <= '0;
            written   <= '0;
            conv_done <= 1'b0;
        end else if (restart) begin
            hex_q       <= hex;
            work_q      <= quo;
            idx_q       <= IDX_W'(1);
            digits[3:0] <= rem;
            written     <= NUM_DIGITS'(1);
            conv_done   <= (NUM_DIGITS == 1);
        end else if (step) begin
            work_q <= quo;
            idx_q  <= idx_q + IDX_W'(1);
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (idx_q == IDX_W'(d)) begin
                    digits[d*4 +: 4] <= rem;
                    written[d]       <= 1'b1;
                end
            end
            if (finish) begin
                conv_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpga_debug_display.sv
// Board debug front end: stage PC or register value on 7-seg, opcode on LEDR.
// Ports: clk, rst_n, taps, selected_reg_value, SW -> HEX_flat, LEDR, conv_done.
// Define FPGA_DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zeros when done.
module fpga_debug_display #(
    parameter int NUM_DIGITS = 6,
    parameter int NUM_STAGES = 7,
    parameter int PC_W       = 7,
    parameter int OP_W       = 7,
    parameter int VALUE_W    = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_STAGES*PC_W-1:0] stage_pc_flat,
    input  logic [NUM_STAGES*OP_W-1:0] stage_opcode_flat,
    input  logic [VALUE_W-1:0]         selected_reg_value,
    input  logic [9:0]                 SW,
    output logic [NUM_DIGITS*7-1:0]    HEX_flat,
    output logic [9:0]                 LEDR,
    output logic                       conv_done
);
    import fpga_debug_pkg::*;

    logic [2:0]            stage_sel;
    logic                  radix;
    logic [3:0]            reg_sel;
    logic                  show_reg;
    logic                  manual;

    assign stage_sel = SW[2:0];
    assign radix     = SW[3];
    assign reg_sel   = SW[7:4];
    assign show_reg  = SW[8];
    assign manual    = SW[9];

    logic [6:0]            sel_key;
    logic [6:0]            sel_q;
    logic                  primed;
    logic                  sel_changed;
    logic                  restart;

    assign sel_key = {manual, show_reg, radix,
                      show_reg ? reg_sel : {1'b0, stage_sel}};
    assign sel_changed = (sel_key != sel_q);
    // The first edge out of reset always starts a conversion.
    assign restart = sel_changed || !primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            primed <= 1'b0;
        end else begin
            primed <= 1'b1;
            if (restart) begin
                sel_q <= sel_key;
            end
        end
    end

    logic                  stage_valid;
    logic [PC_W-1:0]       pc;
    logic [OP_W-1:0]       op;

    assign stage_valid = 32'(stage_sel) < NUM_STAGES;

    always_comb begin
        pc = '0;
        op = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (32'(stage_sel) == s) begin
                pc = stage_pc_flat[s*PC_W +: PC_W];
                op = stage_opcode_flat[s*OP_W +: OP_W];
            end
        end
    end

    logic [VALUE_W-1:0]    source;

    assign source = show_reg ? selected_reg_value : VALUE_W'(pc);

    logic [NUM_DIGITS*4-1:0] digits;
    logic [NUM_DIGITS-1:0]   written;

    digit_serializer #(
        .NUM_DIGITS (NUM_DIGITS),
        .VALUE_W    (VALUE_W)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .hex       (radix),
        .source    (source),
        .digits    (digits),
        .written   (written),
        .conv_done (conv_done)
    );

    logic                  led_on;

    assign led_on = rst_n && manual && !show_reg && stage_valid;
    assign LEDR   = led_on ? ~10'(op) : 10'h3FF;

    logic                  blank_all;

    assign blank_all = !rst_n || !manual || sel_changed
                     || (!show_reg && !stage_valid);

    always_comb begin
        logic [3:0] dv;
        logic       lead;
`ifdef FPGA_DISPLAY_LEADING_ZERO_BLANK_EN
        logic       zero_run;
        zero_run = 1'b1;
`endif
        HEX_flat = {NUM_DIGITS{SEG_BLANK}};
        // Walk from the top digit so leading zeros can be found.
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            dv   = digits[d*4 +: 4];
            lead = 1'b0;
`ifdef FPGA_DISPLAY_LEADING_ZERO_BLANK_EN
            zero_run = zero_run && (dv == 4'd0);
            lead     = conv_done && zero_run && (d != 0);
`endif
            if (!(blank_all || !written[d] || lead)) begin
                HEX_flat[d*7 +: 7] = seg_lut(dv);
            end
        end
    end

endmodule

// File: tb/tb_fpga_debug_display.sv
// Directed scoreboard bench for fpga_debug_display.
// Expected HEX/LEDR/conv_done are queued per step and checked after it.
module tb_fpga_debug_display;

    localparam int ND = 6;
    localparam int NS = 7;
    localparam int PW = 7;
    localparam int OW = 7;
    localparam int VW = 20;
    localparam logic [ND*7-1:0] ALL_BLANK = '1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS*PW-1:0]  stage_pc_flat;
    logic [NS*OW-1:0]  stage_opcode_flat;
    logic [VW-1:0]     selected_reg_value;
    logic [9:0]        SW;
    logic [ND*7-1:0]   HEX_flat;
    logic [9:0]        LEDR;
    logic              conv_done;

    fpga_debug_display dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stage_pc_flat      (stage_pc_flat),
        .stage_opcode_flat  (stage_opcode_flat),
        .selected_reg_value (selected_reg_value),
        .SW                 (SW),
        .HEX_flat           (HEX_flat),
        .LEDR               (LEDR),
        .conv_done          (conv_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           tag;
        logic [ND*7-1:0] hex;
        logic [9:0]      ledr;
        logic            done;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int unsigned pc_tab [NS] = '{0, 13, 27, 99, 88, 100, 127};

    // Display expected after k edges from a restart (k digits written).
    function automatic logic [ND*7-1:0] exp_hex(int unsigned v, bit hx,
                                                 int k);
        logic [ND*7-1:0] r;
        int unsigned     base;
        int unsigned     t;
        int unsigned     dv;
        int              msd;
        r    = '1;
        base = hx ? 16 : 10;
        t    = v;
        msd  = 0;
        for (int d = 0; d < ND; d++) begin
            dv = t % base;
            t  = t / base;
            if (d < k) r[d*7 +: 7] = seg_tab[dv];
            if (dv != 0) msd = d;
        end
`ifdef FPGA_DISPLAY_LEADING_ZERO_BLANK_EN
        if (k >= ND) begin
            for (int d = 1; d < ND; d++) begin
                if (d > msd) r[d*7 +: 7] = 7'b1111111;
            end
        end
`endif
        return r;
    endfunction

    function automatic logic [9:0] led_of(int s);
        return ~10'(s + 1);
    endfunction

    task automatic push(input string tag, input logic [ND*7-1:0] hex,
                        input logic [9:0] ledr, input logic done);
        exp_t e;
        e.tag  = tag;
        e.hex  = hex;
        e.ledr = ledr;
        e.done = done;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard: empty queue at check");
            return;
        end
        e = sb.pop_front();
        assert ({HEX_flat, LEDR, conv_done} === {e.hex, e.ledr, e.done})
        else begin
            miscompares++;
            $error("FAIL %s: got hex=%h ledr=%h done=%b, expected hex=%h ledr=%h done=%b",
                   e.tag, HEX_flat, LEDR, conv_done, e.hex, e.ledr, e.done);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_tick(input string tag, input logic [ND*7-1:0] hex,
                               input logic [9:0] ledr, input logic done);
        push(tag, hex, ledr, done);
        tick();
        check();
    endtask

    task automatic expect_now(input string tag, input logic [ND*7-1:0] hex,
                              input logic [9:0] ledr, input logic done);
        push(tag, hex, ledr, done);
        #2;
        check();
    endtask

    initial begin
        rst_n              = 1'b0;
        SW                 = 10'b11_0000_0000;
        selected_reg_value = VW'(123456);
        for (int s = 0; s < NS; s++) begin
            stage_pc_flat[s*PW +: PW]     = PW'(pc_tab[s]);
            stage_opcode_flat[s*OW +: OW] = OW'(s + 1);
        end

        // Reset state
        expect_now("reset", ALL_BLANK, 10'h3FF, 1'b0);
        rst_n = 1'b1;

        // Reg mode decimal, one digit per edge
        for (int k = 1; k <= ND; k++) begin
            expect_tick($sformatf("dec123456_k%0d", k),
                        exp_hex(123456, 1'b0, k), 10'h3FF, k == ND);
        end

        // 654321 on reg 1, then HOLD ignores value changes
        SW[7:4]            = 4'd1;
        selected_reg_value = VW'(654321);
        for (int k = 1; k < ND; k++) tick();
        expect_tick("full654321", exp_hex(654321, 1'b0, ND), 10'h3FF, 1'b1);
        selected_reg_value = VW'(777);
        expect_tick("hold_frozen", exp_hex(654321, 1'b0, ND), 10'h3FF, 1'b1);

        // Selection change blanks without a clock
        SW[7:4] = 4'd0;
        expect_now("sel_blank", ALL_BLANK, 10'h3FF, 1'b1);
        expect_tick("restart_d0", exp_hex(777, 1'b0, 1), 10'h3FF, 1'b0);

        // Stage mode: stage 0 PC=0
        SW = 10'b10_0000_0000;
        for (int k = 1; k < ND; k++) tick();
        expect_tick("stage0_zero", exp_hex(0, 1'b0, ND), led_of(0), 1'b1);

        // Stage 4 PC=88
        SW[2:0] = 3'd4;
        expect_now("stage4_blank", ALL_BLANK, led_of(4), 1'b1);
        for (int k = 1; k <= ND; k++) begin
            expect_tick($sformatf("stage4_k%0d", k),
                        exp_hex(88, 1'b0, k), led_of(4), k == ND);
        end

        // Hex mode
        SW                 = 10'b11_0000_1000;
        selected_reg_value = 20'hABCDE;
        expect_tick("hex_k1", exp_hex(20'hABCDE, 1'b1, 1), 10'h3FF, 1'b0);
        for (int k = 2; k < ND; k++) tick();
        expect_tick("hex_full", exp_hex(20'hABCDE, 1'b1, ND), 10'h3FF, 1'b1);
        SW[3] = 1'b0;
        expect_now("radix_blank", ALL_BLANK, 10'h3FF, 1'b1);
        expect_tick("radix_dec_k1", exp_hex(20'hABCDE, 1'b0, 1),
                    10'h3FF, 1'b0);

        // LEDR per stage
        for (int s = 0; s < NS; s++) begin
            SW = {2'b10, 4'd0, 1'b0, 3'(s)};
            expect_tick($sformatf("ledr_stage%0d", s),
                        exp_hex(pc_tab[s], 1'b0, 1), led_of(s), 1'b0);
        end

        // Invalid stage
        SW[2:0] = 3'd7;
        expect_tick("stage7_k1", ALL_BLANK, 10'h3FF, 1'b0);
        for (int k = 2; k < ND; k++) tick();
        expect_tick("stage7_done", ALL_BLANK, 10'h3FF, 1'b1);

        // Manual mode off: conversion runs but display blank
        SW                 = 10'b01_0000_0000;
        selected_reg_value = VW'(4321);
        for (int k = 1; k < ND; k++) tick();
        expect_tick("manual_off", ALL_BLANK, 10'h3FF, 1'b1);

        // Reset mid-conversion
        SW[9] = 1'b1;
        tick();
        tick();
        expect_tick("pre_reset_k3", exp_hex(4321, 1'b0, 3), 10'h3FF, 1'b0);
        rst_n = 1'b0;
        expect_now("mid_reset", ALL_BLANK, 10'h3FF, 1'b0);
        rst_n = 1'b1;
        expect_tick("post_reset_k1", exp_hex(4321, 1'b0, 1), 10'h3FF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
